// File: rtl/mem_stage_lsu.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage_lsu
//  Description : Memory-stage load/store responder. Accepts one memory op at
//                a time from the EX/MEM register, performs it on a local
//                word-organised data RAM after MEM_LAT cycles, and returns a
//                completion (load data or store ack) tagged with the PC.
//  Ports       : clk, rstn (async, active-low)
//                i_req_valid/o_req_ready handshake; i_req_read, i_req_write,
//                i_req_op[3:0], i_req_addr[31:0], i_req_wdata[31:0],
//                i_req_pc[31:0] request fields
//                o_resp_valid/i_resp_ready handshake; o_resp_rdata[31:0],
//                o_resp_pc[31:0], o_resp_is_ld, o_resp_err response fields
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_stage_lsu #(
   parameter int DEPTH   = 256,
   parameter int MEM_LAT = 2
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        i_req_valid,
   output logic        o_req_ready,
   input  logic        i_req_read,
   input  logic        i_req_write,
   input  logic [3:0]  i_req_op,
   input  logic [31:0] i_req_addr,
   input  logic [31:0] i_req_wdata,
   input  logic [31:0] i_req_pc,
   output logic        o_resp_valid,
   input  logic        i_resp_ready,
   output logic [31:0] o_resp_rdata,
   output logic [31:0] o_resp_pc,
   output logic        o_resp_is_ld,
   output logic        o_resp_err
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam logic [CW-1:0] c_CNT_INIT = CW'(MEM_LAT - 1);

   localparam logic [1:0] c_ST_IDLE = 2'd0;
   localparam logic [1:0] c_ST_BUSY = 2'd1;
   localparam logic [1:0] c_ST_RESP = 2'd2;

   logic [1:0]    r_state;
   logic [1:0]    w_state_nxt;
   logic [CW-1:0] r_cnt;

   // Latched request
   logic          r_rd;
   logic          r_wr;
   logic [2:0]    r_op;
   logic [AW+1:0] r_addr;
   logic [31:0]   r_wdata;
   logic [31:0]   r_pc;

   logic [31:0]   r_mem [DEPTH];

   logic          w_req_ready;
   logic          w_accept;
   logic          w_do_access;
   logic [AW-1:0] w_idx;

   logic          w_op_legal;
   logic          w_is_half;
   logic          w_is_word;
   logic          w_illegal;
   logic          w_misal;
   logic          w_err;

   logic [3:0]    w_be;
   logic [31:0]   w_st_data;
   logic          w_mem_we;

   logic [31:0]   w_rd_word;
   logic [7:0]    w_byte;
   logic [15:0]   w_half;
   logic [31:0]   w_ld_val;

   // op[3] and the address bits above the RAM span carry no meaning here
   logic          w_unused;
   assign w_unused = ^{i_req_op[3], i_req_addr[31:AW+2]};

   assign w_accept    = i_req_valid & w_req_ready;
   assign w_do_access = (r_state == c_ST_BUSY) && (r_cnt == '0);
   assign w_idx       = r_addr[AW+1:2];

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= c_ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_ST_IDLE: if (w_accept)    w_state_nxt = c_ST_BUSY;
         c_ST_BUSY: if (w_do_access) w_state_nxt = c_ST_RESP;
         c_ST_RESP: begin
            // Back-to-back: a request seen while the response drains goes
            // straight to BUSY without an IDLE bubble.
            if (i_resp_ready) w_state_nxt = i_req_valid ? c_ST_BUSY : c_ST_IDLE;
         end
         default:   w_state_nxt = c_ST_IDLE;
      endcase
   end

   always_comb begin
      w_req_ready  = (r_state == c_ST_IDLE) | ((r_state == c_ST_RESP) & i_resp_ready);
      o_req_ready  = w_req_ready;
      o_resp_valid = (r_state == c_ST_RESP);
   end

   // ------------------------------------------------ latency counter / latch
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_cnt   <= '0;
         r_rd    <= 1'b0;
         r_wr    <= 1'b0;
         r_op    <= '0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_pc    <= '0;
      end else if (w_accept) begin
         r_cnt   <= c_CNT_INIT;
         r_rd    <= i_req_read;
         r_wr    <= i_req_write;
         r_op    <= i_req_op[2:0];
         r_addr  <= i_req_addr[AW+1:0];
         r_wdata <= i_req_wdata;
         r_pc    <= i_req_pc;
      end else if ((r_state == c_ST_BUSY) && (r_cnt != '0)) begin
         r_cnt   <= r_cnt - 1'b1;
      end
   end

   // ------------------------------------------------------- op decode
   assign w_op_legal = (r_op == 3'b000) | (r_op == 3'b001) | (r_op == 3'b010) |
                       (r_op == 3'b100) | (r_op == 3'b101);
   assign w_is_half  = (r_op[1:0] == 2'b01);
   assign w_is_word  = (r_op[1:0] == 2'b10);
   // Unsigned sizes only make sense for loads
   assign w_illegal  = (r_rd & r_wr) | (~r_rd & ~r_wr) | ~w_op_legal | (r_wr & r_op[2]);
   assign w_misal    = (w_is_half & r_addr[0]) | (w_is_word & (r_addr[1:0] != 2'b00));
   assign w_err      = w_illegal | w_misal;

   // ---------------------------------------------------------- store path
   always_comb begin
      w_be      = 4'b0000;
      w_st_data = r_wdata;
      case (r_op[1:0])
         2'b00: begin
            w_be      = 4'b0001 << r_addr[1:0];
            w_st_data = {4{r_wdata[7:0]}};
         end
         2'b01: begin
            w_be      = r_addr[1] ? 4'b1100 : 4'b0011;
            w_st_data = {2{r_wdata[15:0]}};
         end
         default: begin
            w_be      = 4'b1111;
            w_st_data = r_wdata;
         end
      endcase
   end

   assign w_mem_we = w_do_access & r_wr & ~w_err;

   // RAM is intentionally not reset
   always_ff @(posedge clk) begin
      if (w_mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (w_be[b]) r_mem[w_idx][b*8 +: 8] <= w_st_data[b*8 +: 8];
         end
      end
   end

   // ----------------------------------------------------------- load path
   assign w_rd_word = r_mem[w_idx];
   assign w_byte    = w_rd_word[{r_addr[1:0], 3'b000} +: 8];
   assign w_half    = r_addr[1] ? w_rd_word[31:16] : w_rd_word[15:0];

   always_comb begin
      w_ld_val = w_rd_word;
      case (r_op[1:0])
         2'b00:   w_ld_val = r_op[2] ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
         2'b01:   w_ld_val = r_op[2] ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
         default: w_ld_val = w_rd_word;
      endcase
   end

   // ------------------------------------------------------ response regs
   // Loaded only on the BUSY->RESP edge, so they hold through back-pressure
   // and keep their last value once the response has been consumed.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         o_resp_rdata <= '0;
         o_resp_pc    <= '0;
         o_resp_is_ld <= 1'b0;
         o_resp_err   <= 1'b0;
      end else if (w_do_access) begin
         o_resp_rdata <= (r_rd & ~w_err) ? w_ld_val : 32'd0;
         o_resp_pc    <= r_pc;
         o_resp_is_ld <= r_rd & ~w_err;
         o_resp_err   <= w_err;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_lsu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_stage_lsu
//  Description : Directed self-checking bench for mem_stage_lsu.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage_lsu;

   logic        clk;
   logic        rstn;
   logic        req_valid;
   logic        req_ready;
   logic        req_read;
   logic        req_write;
   logic [3:0]  req_op;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [31:0] req_pc;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic [31:0] resp_pc;
   logic        resp_is_ld;
   logic        resp_err;

   int vectors;
   int miscompares;

   localparam logic [3:0] OP_B  = 4'b0000;
   localparam logic [3:0] OP_H  = 4'b0001;
   localparam logic [3:0] OP_W  = 4'b0010;
   localparam logic [3:0] OP_BU = 4'b0100;
   localparam logic [3:0] OP_HU = 4'b0101;

   mem_stage_lsu #(.DEPTH(256), .MEM_LAT(2)) dut (
      .clk          (clk),
      .rstn         (rstn),
      .i_req_valid  (req_valid),
      .o_req_ready  (req_ready),
      .i_req_read   (req_read),
      .i_req_write  (req_write),
      .i_req_op     (req_op),
      .i_req_addr   (req_addr),
      .i_req_wdata  (req_wdata),
      .i_req_pc     (req_pc),
      .o_resp_valid (resp_valid),
      .i_resp_ready (resp_ready),
      .o_resp_rdata (resp_rdata),
      .o_resp_pc    (resp_pc),
      .o_resp_is_ld (resp_is_ld),
      .o_resp_err   (resp_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic rd, input logic wr, input logic [3:0] op,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] pc);
      req_valid = 1'b1;
      req_read  = rd;
      req_write = wr;
      req_op    = op;
      req_addr  = addr;
      req_wdata = wd;
      req_pc    = pc;
   endtask

   // Full transaction from IDLE: accept, check latency, check response, drain.
   task automatic xact(input logic rd, input logic wr, input logic [3:0] op,
                       input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] pc,
                       input logic [31:0] exp_rdata, input logic exp_ld, input logic exp_err,
                       input string tag);
      @(negedge clk);
      chk({31'd0, req_ready}, 32'd1, {tag, ".idle_ready"});
      drive(rd, wr, op, addr, wd, pc);
      @(negedge clk);               // accepted on the edge just passed
      req_valid = 1'b0;
      chk({31'd0, resp_valid}, 32'd0, {tag, ".lat1"});
      chk({31'd0, req_ready},  32'd0, {tag, ".busy_ready"});
      @(negedge clk);
      chk({31'd0, resp_valid}, 32'd0, {tag, ".lat2"});
      @(negedge clk);
      chk({31'd0, resp_valid}, 32'd1, {tag, ".valid"});
      chk({31'd0, req_ready},  32'd0, {tag, ".resp_ready_lo"});
      chk(resp_rdata, exp_rdata, {tag, ".rdata"});
      chk(resp_pc, pc, {tag, ".pc"});
      chk({31'd0, resp_is_ld}, {31'd0, exp_ld},  {tag, ".is_ld"});
      chk({31'd0, resp_err},   {31'd0, exp_err}, {tag, ".err"});
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      chk({31'd0, resp_valid}, 32'd0, {tag, ".drained"});
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rstn        = 1'b0;
      req_valid   = 1'b0;
      req_read    = 1'b0;
      req_write   = 1'b0;
      req_op      = 4'd0;
      req_addr    = 32'd0;
      req_wdata   = 32'd0;
      req_pc      = 32'd0;
      resp_ready  = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      chk({31'd0, req_ready},  32'd1, "rst.req_ready");
      chk({31'd0, resp_valid}, 32'd0, "rst.resp_valid");
      chk(resp_rdata, 32'd0, "rst.rdata");
      chk(resp_pc, 32'd0, "rst.pc");
      chk({31'd0, resp_is_ld}, 32'd0, "rst.is_ld");
      chk({31'd0, resp_err},   32'd0, "rst.err");
      rstn = 1'b1;

      // 1: word store / load
      xact(0, 1, OP_W,  32'h10, 32'hDEADBEEF, 32'h100, 32'h0,        0, 0, "sw10");
      xact(1, 0, OP_W,  32'h10, 32'h0,        32'h104, 32'hDEADBEEF, 1, 0, "lw10");
      // 2: sub-word loads with extension
      xact(1, 0, OP_B,  32'h13, 32'h0, 32'h108, 32'hFFFFFFDE, 1, 0, "lb13");
      xact(1, 0, OP_BU, 32'h13, 32'h0, 32'h10C, 32'h000000DE, 1, 0, "lbu13");
      xact(1, 0, OP_H,  32'h12, 32'h0, 32'h110, 32'hFFFFDEAD, 1, 0, "lh12");
      xact(1, 0, OP_HU, 32'h10, 32'h0, 32'h114, 32'h0000BEEF, 1, 0, "lhu10");
      xact(1, 0, OP_B,  32'h10, 32'h0, 32'h118, 32'hFFFFFFEF, 1, 0, "lb10");
      // 3: byte store, misaligned accesses, illegal ops
      xact(0, 1, OP_B,  32'h11, 32'h00000055, 32'h11C, 32'h0, 0, 0, "sb11");
      xact(1, 0, OP_W,  32'h10, 32'h0, 32'h120, 32'hDEAD55EF, 1, 0, "lw10b");
      xact(1, 0, OP_H,  32'h11, 32'h0, 32'h124, 32'h0, 0, 1, "lh11_mis");
      xact(0, 1, OP_W,  32'h12, 32'hCAFEF00D, 32'h128, 32'h0, 0, 1, "sw12_mis");
      xact(0, 1, OP_BU, 32'h10, 32'h000000AA, 32'h12C, 32'h0, 0, 1, "sbu_ill");
      xact(1, 0, 4'b0011, 32'h10, 32'h0, 32'h130, 32'h0, 0, 1, "op3_ill");
      xact(0, 0, OP_W,  32'h10, 32'h0, 32'h134, 32'h0, 0, 1, "none_ill");
      xact(1, 0, 4'b1010, 32'h10, 32'h0, 32'h138, 32'hDEAD55EF, 1, 0, "lw_op3ign");
      xact(0, 1, OP_H,  32'h12, 32'h00007777, 32'h13C, 32'h0, 0, 0, "sh12");
      xact(1, 0, OP_W,  32'h10, 32'h0, 32'h140, 32'h777755EF, 1, 0, "lw10c");

      // 5: address aliasing and read&write
      xact(0, 1, OP_W,  32'h400, 32'h00001234, 32'h200, 32'h0, 0, 0, "sw400");
      xact(1, 0, OP_W,  32'h0,   32'h0, 32'h204, 32'h00001234, 1, 0, "lw0");
      xact(1, 1, OP_W,  32'h0,   32'h0, 32'h208, 32'h0, 0, 1, "rw_ill");

      // 4: back-pressure with a pending request, then same-cycle accept
      @(negedge clk);
      drive(1, 0, OP_W, 32'h10, 32'h0, 32'h300);
      @(negedge clk);
      drive(1, 0, OP_W, 32'h0, 32'h0, 32'h304);   // second request waits
      @(negedge clk);
      @(negedge clk);
      chk({31'd0, resp_valid}, 32'd1, "bp.valid");
      for (int i = 0; i < 5; i++) begin
         chk(resp_rdata, 32'h777755EF, "bp.hold_rdata");
         chk(resp_pc, 32'h300, "bp.hold_pc");
         chk({31'd0, resp_valid}, 32'd1, "bp.hold_valid");
         chk({31'd0, req_ready},  32'd0, "bp.hold_ready");
         @(negedge clk);
      end
      resp_ready = 1'b1;
      #1;
      chk({31'd0, req_ready}, 32'd1, "bp.ready_on_drain");
      @(negedge clk);
      resp_ready = 1'b0;
      req_valid  = 1'b0;
      chk({31'd0, resp_valid}, 32'd0, "bp.b2b_lat1");
      chk({31'd0, req_ready},  32'd0, "bp.b2b_busy");
      @(negedge clk);
      chk({31'd0, resp_valid}, 32'd0, "bp.b2b_lat2");
      @(negedge clk);
      chk({31'd0, resp_valid}, 32'd1, "bp.b2b_valid");
      chk(resp_rdata, 32'h00001234, "bp.b2b_rdata");
      chk(resp_pc, 32'h304, "bp.b2b_pc");
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      chk({31'd0, req_ready}, 32'd1, "bp.back_idle");

      // 6: reset while a store is in flight drops it
      xact(0, 1, OP_W, 32'h20, 32'h11112222, 32'h400, 32'h0, 0, 0, "sw20");
      xact(1, 0, OP_W, 32'h20, 32'h0, 32'h404, 32'h11112222, 1, 0, "lw20");
      @(negedge clk);
      drive(0, 1, OP_W, 32'h20, 32'hA5A5A5A5, 32'h408);
      @(negedge clk);
      req_valid = 1'b0;
      rstn      = 1'b0;
      #1;
      chk({31'd0, req_ready},  32'd1, "arst.req_ready");
      chk({31'd0, resp_valid}, 32'd0, "arst.resp_valid");
      chk(resp_rdata, 32'd0, "arst.rdata");
      chk(resp_pc, 32'd0, "arst.pc");
      chk({31'd0, resp_is_ld}, 32'd0, "arst.is_ld");
      chk({31'd0, resp_err},   32'd0, "arst.err");
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      xact(1, 0, OP_W, 32'h20, 32'h0, 32'h40C, 32'h11112222, 1, 0, "lw20_after_rst");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
